// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared CPU definitions for the EX->MEM stage: store-data forward selects and
// bit positions of the MEM/WB control bundle.
// No logic, no latency, no flow control; constants and types only.
package ex_mem_pipe_stage_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_ILL = 2'b11
    } fwd_sel_e;

    // Control bundle layout, LSB first
    localparam int CTRL_MEM_READ  = 0;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_SIZE_LO   = 4;
    localparam int CTRL_SIZE_HI   = 5;
    localparam int CTRL_MIN_W     = 6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on reset.
// Latency: count reflects inc one clock later.
// Backpressure: none; inc is sampled every cycle.
module sat_counter
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != MAX)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid, stall hold, flush bubble and store-data forwarding.
// Latency: 1 cycle, all outputs registered.
// Backpressure: stall holds contents; flush overrides stall and loads a bubble.
module ex_mem_pipe_stage
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int DATA_W = 133,
    parameter int CTRL_W = 6,
    parameter int XLEN   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctr_in,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        fwd_sel,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic [XLEN-1:0]   mem_alu_out,
    input  logic [XLEN-1:0]   wb_databus_c,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctr_out,
    output logic              valid_out,
    output logic [XLEN-1:0]   store_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              vld;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] dat;
        logic [XLEN-1:0]   store;
    } stage_t;

    stage_t          stage_d;
    stage_t          stage_q;
    logic [XLEN-1:0] fwd_dat;
    logic            stall_inc;
    logic            bubble_inc;

    // The illegal 11 encoding deliberately falls back to the register-file value
    always_comb begin
        fwd_dat = rs2_in;
        case (fwd_sel_e'(fwd_sel))
            FWD_MEM: fwd_dat = mem_alu_out;
            FWD_WB:  fwd_dat = wb_databus_c;
            default: fwd_dat = rs2_in;
        endcase
    end

    always_comb begin
        stage_d    = stage_q;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (flush) begin
            stage_d    = '0;
            bubble_inc = 1'b1;
        end else if (stall) begin
            stall_inc = 1'b1;
        end else begin
            stage_d.vld   = valid_in;
            stage_d.ctrl  = valid_in ? ctr_in : '0;
            stage_d.dat   = data_in;
            stage_d.store = fwd_dat;
            bubble_inc    = ~valid_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_out   = stage_q.dat;
    assign ctr_out    = stage_q.ctrl;
    assign valid_out  = stage_q.vld;
    assign store_data = stage_q.store;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: directed scenarios then random traffic.
module tb_ex_mem_pipe_stage;

    localparam int DATA_W = 133;
    localparam int CTRL_W = 6;
    localparam int XLEN   = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic [CTRL_W-1:0] ctr_in = '0;
    logic              valid_in = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        fwd_sel = 2'b00;
    logic [XLEN-1:0]   rs2_in = '0;
    logic [XLEN-1:0]   mem_alu_out = '0;
    logic [XLEN-1:0]   wb_databus_c = '0;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctr_out;
    logic              valid_out;
    logic [XLEN-1:0]   store_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    ex_mem_pipe_stage #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .XLEN(XLEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(rst_n),
        .data_in(data_in), .ctr_in(ctr_in), .valid_in(valid_in),
        .stall(stall), .flush(flush), .fwd_sel(fwd_sel),
        .rs2_in(rs2_in), .mem_alu_out(mem_alu_out), .wb_databus_c(wb_databus_c),
        .data_out(data_out), .ctr_out(ctr_out), .valid_out(valid_out),
        .store_data(store_data), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] dat;
        logic [CTRL_W-1:0] ctrl;
        logic              vld;
        logic [XLEN-1:0]   store;
        int                stalls;
        int                bubbles;
    } exp_t;

    exp_t model;
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        model.dat = '0; model.ctrl = '0; model.vld = 1'b0; model.store = '0;
        model.stalls = 0; model.bubbles = 0;
    endfunction

    // Expected next state from the stage rules: flush beats stall beats load
    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic [1:0] fs, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb,
                         input logic st, input logic fl);
        valid_in = v; ctr_in = c; data_in = d; fwd_sel = fs;
        rs2_in = rs2; mem_alu_out = mem; wb_databus_c = wb; stall = st; flush = fl;
        if (fl) begin
            model.dat = '0; model.ctrl = '0; model.vld = 1'b0; model.store = '0;
            if (model.bubbles < CMAX) model.bubbles = model.bubbles + 1;
        end else if (st) begin
            if (model.stalls < CMAX) model.stalls = model.stalls + 1;
        end else begin
            model.dat = d;
            model.vld = v;
            model.ctrl = v ? c : '0;
            if (fs == 2'b10)      model.store = mem;
            else if (fs == 2'b01) model.store = wb;
            else                  model.store = rs2;
            if (!v && model.bubbles < CMAX) model.bubbles = model.bubbles + 1;
        end
        exp_q.push_back(model);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    // Monitor: the stage presents a result every cycle out of reset
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid_out", DATA_W'(valid_out), DATA_W'(e.vld));
            chk("ctr_out", DATA_W'(ctr_out), DATA_W'(e.ctrl));
            chk("data_out", data_out, e.dat);
            chk("store_data", DATA_W'(store_data), DATA_W'(e.store));
            chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(e.stalls));
            chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(e.bubbles));
            if (!valid_out) chk("bubble_ctrl_zero", DATA_W'(ctr_out), '0);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, data_out, '0);
        chk({tag, "_ctrl"}, DATA_W'(ctr_out), '0);
        chk({tag, "_valid"}, DATA_W'(valid_out), '0);
        chk({tag, "_store"}, DATA_W'(store_data), '0);
        chk({tag, "_stall_cnt"}, DATA_W'(stall_cnt), '0);
        chk({tag, "_bubble_cnt"}, DATA_W'(bubble_cnt), '0);
    endtask

    task automatic pulse_reset(input string tag);
        drive(1'b1, 6'h3F, rnd_data(), 2'b10, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
        drive(1'b1, 6'h15, rnd_data(), 2'b01, 32'h4, 32'h5, 32'h6, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_all_zero(tag);
        model_clear();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset_init");
        @(negedge clk);
        #1 rst_n = 1'b1;

        drive(1'b1, 6'h2A, 133'h1F, 2'b00, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 6'h01, 133'h2, 2'b10, 32'h55, 32'hDEAD, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 6'h02, 133'h3, 2'b01, 32'h55, 32'h0, 32'hBEEF, 1'b0, 1'b0);
        drive(1'b1, 6'h03, 133'h4, 2'b11, 32'h77, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);

        pulse_reset("reset_mid");
        drive(1'b1, 6'h2A, 133'hA5A5, 2'b10, 32'h11, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 6'(i + 5), rnd_data(), 2'(i), $urandom, $urandom, $urandom, 1'b1, 1'b0);
        chk("stall_cnt_three", DATA_W'(stall_cnt), DATA_W'(3));
        chk("stall_hold_store", DATA_W'(store_data), DATA_W'(32'hAAAA));

        drive(1'b1, 6'h3F, rnd_data(), 2'b00, 32'h9, 32'h0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 6'h3F, rnd_data(), 2'b00, 32'h9, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("invalid_load_ctrl", DATA_W'(ctr_out), '0);

        for (int i = 0; i < 20; i++)
            drive(1'b1, 6'h11, rnd_data(), 2'b10, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        chk("stall_saturated", DATA_W'(stall_cnt), DATA_W'(4'hF));
        drive(1'b1, 6'h11, rnd_data(), 2'b00, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        chk("stall_stays_sat", DATA_W'(stall_cnt), DATA_W'(4'hF));

        pulse_reset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            logic st, fl;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            drive(($urandom_range(0, 3) != 0), 6'($urandom), rnd_data(), 2'($urandom),
                  $urandom, $urandom, $urandom, st, fl);
            if (i == 200) pulse_reset("reset_late");
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", DATA_W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
